// File: rtl/dallanma_denetleyici_pkg.sv
// Shared constants and types for the branch-resolution controller.
// Holds the FSM state encodings, the instruction size used for the
// fall-through PC, the redirect source (branch-type) codes and the
// saturating counter helper used when DALLANMA_SAYAC_EN is defined.
package dallanma_denetleyici_pkg;

    // FSM state encodings
    localparam logic [0:0] BOSTA     = 1'b0;
    localparam logic [0:0] YONLENDIR = 1'b1;

    // Size of one instruction in bytes; not-taken path is PC + KOMUT_BOYU
    localparam int unsigned KOMUT_BOYU = 4;

    // Performance counter width
    localparam int unsigned SAYAC_W = 32;

    // Branch-type codes: which source, if any, drives the redirect
    typedef enum logic [1:0] {
        DAL_YOK     = 2'd0,
        DAL_KOSULLU = 2'd1,
        DAL_ATLAMA  = 2'd2
    } dal_tipi_t;

`ifdef DALLANMA_SAYAC_EN
    // Increment that sticks at all-ones
    function automatic logic [SAYAC_W-1:0] doyumlu_artir(input logic [SAYAC_W-1:0] x);
        return (x == {SAYAC_W{1'b1}}) ? x : x + SAYAC_W'(1);
    endfunction
`endif

endpackage

// File: rtl/dallanma_denetleyici_if.sv
// Execute/fetch/predictor-side signal bundle of the branch controller.
// slave  : view of the controller (inputs from execute/fetch/predictor,
//          redirect, flush/stall, predictor update and counter outputs)
// master : view of the surrounding pipeline / testbench
interface dallanma_denetleyici_if #(
    parameter int unsigned PS_W = 32
);
    logic            dal_gecerli_i;
    logic            dal_hata_i;
    logic            dal_atladi_i;
    logic [PS_W-1:0] dal_ps_i;
    logic [PS_W-1:0] dal_hedef_i;
    logic            atlama_gecerli_i;
    logic [PS_W-1:0] atlama_hedef_i;
    logic            getir_hazir_i;
    logic            ongorucu_hazir_i;

    logic            yonlendir_gecerli_o;
    logic [PS_W-1:0] yonlendir_ps_o;
    logic            temizle_o;
    logic            durdur_o;
    logic            guncelle_gecerli_o;
    logic            guncelle_atladi_o;
    logic [PS_W-1:0] guncelle_ps_o;
    logic [PS_W-1:0] guncelle_hedef_o;
    logic [31:0]     dal_sayisi_o;
    logic [31:0]     hata_sayisi_o;

    modport slave (
        input  dal_gecerli_i, dal_hata_i, dal_atladi_i, dal_ps_i, dal_hedef_i,
        input  atlama_gecerli_i, atlama_hedef_i, getir_hazir_i, ongorucu_hazir_i,
        output yonlendir_gecerli_o, yonlendir_ps_o, temizle_o, durdur_o,
        output guncelle_gecerli_o, guncelle_atladi_o, guncelle_ps_o, guncelle_hedef_o,
        output dal_sayisi_o, hata_sayisi_o
    );

    modport master (
        output dal_gecerli_i, dal_hata_i, dal_atladi_i, dal_ps_i, dal_hedef_i,
        output atlama_gecerli_i, atlama_hedef_i, getir_hazir_i, ongorucu_hazir_i,
        input  yonlendir_gecerli_o, yonlendir_ps_o, temizle_o, durdur_o,
        input  guncelle_gecerli_o, guncelle_atladi_o, guncelle_ps_o, guncelle_hedef_o,
        input  dal_sayisi_o, hata_sayisi_o
    );
endinterface

// File: rtl/dallanma_guncelle_fifo.sv
// Predictor-update queue.
// Ports: clk_i, rst_i (async, active-low); yaz_i/veri_i push request and
// payload (refused while full); oku_i pop request (honoured while
// gecerli_o); veri_o head entry; gecerli_o nonempty; dolu_o full;
// dolu_sonraki_c full-after-this-edge, for callers that register a stall.
module dallanma_guncelle_fifo #(
    parameter int unsigned GENISLIK = 65,
    parameter int unsigned DERINLIK = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                yaz_i,
    input  logic [GENISLIK-1:0] veri_i,
    input  logic                oku_i,
    output logic [GENISLIK-1:0] veri_o,
    output logic                gecerli_o,
    output logic                dolu_o,
    output logic                dolu_sonraki_c
);
    localparam int unsigned AW    = $clog2(DERINLIK);
    localparam int unsigned SAY_W = AW + 1;

    logic [GENISLIK-1:0] bellek [DERINLIK];
    logic [AW-1:0]       yaz_ptr_q;
    logic [AW-1:0]       oku_ptr_q;
    logic [SAY_W-1:0]    sayac_q;
    logic [SAY_W-1:0]    sayac_d;
    logic                gecerli_q;
    logic                dolu_q;
    logic                it;
    logic                cek;

    // Accepted push/pop for this cycle
    assign it      = yaz_i && !dolu_q;
    assign cek     = oku_i && gecerli_q;
    assign sayac_d = sayac_q + SAY_W'(it) - SAY_W'(cek);

    assign dolu_sonraki_c = (sayac_d == SAY_W'(DERINLIK));

    // Storage, pointers and occupancy; pointers wrap naturally at 2^AW
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DERINLIK); i++) begin
                bellek[i] <= '0;
            end
            yaz_ptr_q <= '0;
            oku_ptr_q <= '0;
            sayac_q   <= '0;
            gecerli_q <= 1'b0;
            dolu_q    <= 1'b0;
        end else begin
            if (it) begin
                bellek[yaz_ptr_q] <= veri_i;
                yaz_ptr_q         <= yaz_ptr_q + AW'(1);
            end
            if (cek) begin
                oku_ptr_q <= oku_ptr_q + AW'(1);
            end
            sayac_q   <= sayac_d;
            gecerli_q <= (sayac_d != '0);
            dolu_q    <= dolu_sonraki_c;
        end
    end

    assign veri_o    = bellek[oku_ptr_q];
    assign gecerli_o = gecerli_q;
    assign dolu_o    = dolu_q;

endmodule

// File: rtl/dallanma_denetleyici.sv
// Branch-resolution controller: turns execute-stage mispredicts and
// unconditional jumps into a held fetch redirect with a one-cycle IF/ID
// flush, stalls execute while redirecting or while the predictor-update
// queue is full, and queues every accepted branch for the predictor.
// Ports: clk_i, rst_i (async, active-low); bus (slave modport) carries
// branch/jump inputs, fetch/predictor ready, redirect, temizle_o/durdur_o,
// predictor update and the two performance counters.
// Option: DALLANMA_SAYAC_EN enables the saturating branch/mispredict
// counters; otherwise the counter outputs are tied to 0.
module dallanma_denetleyici
    import dallanma_denetleyici_pkg::*;
#(
    parameter int unsigned PS_W          = 32,
    parameter int unsigned FIFO_DERINLIK = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dallanma_denetleyici_if.slave bus
);
    localparam int unsigned KAYIT_W = 2 * PS_W + 1;

    logic [0:0]         durum_q;
    logic [0:0]         durum_d;
    logic [PS_W-1:0]    yon_ps_q;
    logic [PS_W-1:0]    yon_ps_d;
    logic               yon_gecerli_q;
    logic               durdur_q;
    dal_tipi_t          kaynak;

    logic               fifo_yaz;
    logic               fifo_dolu;
    logic               fifo_dolu_sonraki;
    logic               fifo_gecerli;
    logic [KAYIT_W-1:0] fifo_cikis;

    // Next state and redirect PC; branch mispredict wins over a jump
    always_comb begin
        durum_d  = durum_q;
        yon_ps_d = yon_ps_q;
        kaynak   = DAL_YOK;
        fifo_yaz = 1'b0;
        case (durum_q)
            BOSTA: begin
                fifo_yaz = bus.dal_gecerli_i;
                if (bus.dal_gecerli_i && bus.dal_hata_i) begin
                    // A refused (queue full) mispredict is retried; jump stays discarded
                    if (!fifo_dolu) begin
                        kaynak = DAL_KOSULLU;
                    end
                end else if (bus.atlama_gecerli_i) begin
                    kaynak = DAL_ATLAMA;
                end
                case (kaynak)
                    DAL_KOSULLU: begin
                        yon_ps_d = bus.dal_atladi_i ? bus.dal_hedef_i
                                                    : bus.dal_ps_i + PS_W'(KOMUT_BOYU);
                        durum_d  = YONLENDIR;
                    end
                    DAL_ATLAMA: begin
                        yon_ps_d = bus.atlama_hedef_i;
                        durum_d  = YONLENDIR;
                    end
                    default: ;
                endcase
            end
            YONLENDIR: begin
                if (bus.getir_hazir_i) begin
                    durum_d = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q       <= BOSTA;
            yon_ps_q      <= '0;
            yon_gecerli_q <= 1'b0;
            durdur_q      <= 1'b0;
        end else begin
            durum_q       <= durum_d;
            yon_ps_q      <= yon_ps_d;
            yon_gecerli_q <= (durum_d == YONLENDIR);
            durdur_q      <= (durum_d == YONLENDIR) || fifo_dolu_sonraki;
        end
    end

    dallanma_guncelle_fifo #(
        .GENISLIK (KAYIT_W),
        .DERINLIK (FIFO_DERINLIK)
    ) u_fifo (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .yaz_i          (fifo_yaz),
        .veri_i         ({bus.dal_ps_i, bus.dal_atladi_i, bus.dal_hedef_i}),
        .oku_i          (bus.ongorucu_hazir_i),
        .veri_o         (fifo_cikis),
        .gecerli_o      (fifo_gecerli),
        .dolu_o         (fifo_dolu),
        .dolu_sonraki_c (fifo_dolu_sonraki)
    );

    assign bus.yonlendir_gecerli_o = yon_gecerli_q;
    assign bus.yonlendir_ps_o      = yon_ps_q;
    // Flush is the handshake cycle itself, so it cannot come from a flop
    assign bus.temizle_o           = yon_gecerli_q && bus.getir_hazir_i;
    assign bus.durdur_o            = durdur_q;
    assign bus.guncelle_gecerli_o  = fifo_gecerli;
    assign bus.guncelle_ps_o       = fifo_cikis[KAYIT_W-1 -: PS_W];
    assign bus.guncelle_atladi_o   = fifo_cikis[PS_W];
    assign bus.guncelle_hedef_o    = fifo_cikis[PS_W-1:0];

`ifdef DALLANMA_SAYAC_EN
    logic [SAYAC_W-1:0] dal_sayisi_q;
    logic [SAYAC_W-1:0] hata_sayisi_q;
    logic               dal_kabul;

    assign dal_kabul = fifo_yaz && !fifo_dolu;

    // Saturating counts of accepted branches and accepted mispredicts
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dal_sayisi_q  <= '0;
            hata_sayisi_q <= '0;
        end else if (dal_kabul) begin
            dal_sayisi_q <= doyumlu_artir(dal_sayisi_q);
            if (bus.dal_hata_i) begin
                hata_sayisi_q <= doyumlu_artir(hata_sayisi_q);
            end
        end
    end

    assign bus.dal_sayisi_o  = dal_sayisi_q;
    assign bus.hata_sayisi_o = hata_sayisi_q;
`else
    assign bus.dal_sayisi_o  = '0;
    assign bus.hata_sayisi_o = '0;
`endif

endmodule

// File: tb/tb_dallanma_denetleyici.sv
// Directed self-checking bench for dallanma_denetleyici.
module tb_dallanma_denetleyici;

    logic clk_i;
    logic rst_i;
    int   hatalar;
    int   kontroller;

    dallanma_denetleyici_if #(.PS_W(32)) bus ();

    dallanma_denetleyici #(
        .PS_W          (32),
        .FIFO_DERINLIK (4)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        kontroller++;
        assert (gozlenen === beklenen) else begin
            hatalar++;
            $error("FAIL %s: observed=%0h expected=%0h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic adim();
        @(posedge clk_i);
        #1;
    endtask

    task automatic girisleri_sil();
        bus.dal_gecerli_i    = 1'b0;
        bus.dal_hata_i       = 1'b0;
        bus.dal_atladi_i     = 1'b0;
        bus.dal_ps_i         = '0;
        bus.dal_hedef_i      = '0;
        bus.atlama_gecerli_i = 1'b0;
        bus.atlama_hedef_i   = '0;
    endtask

    task automatic dal(input logic hata, input logic atladi,
                       input logic [31:0] ps, input logic [31:0] hedef);
        bus.dal_gecerli_i = 1'b1;
        bus.dal_hata_i    = hata;
        bus.dal_atladi_i  = atladi;
        bus.dal_ps_i      = ps;
        bus.dal_hedef_i   = hedef;
    endtask

    task automatic hepsi_sifir(input string on_ek);
        kontrol({on_ek, "_yon_gecerli"}, 32'(bus.yonlendir_gecerli_o), 32'd0);
        kontrol({on_ek, "_yon_ps"},      bus.yonlendir_ps_o,           32'd0);
        kontrol({on_ek, "_temizle"},     32'(bus.temizle_o),           32'd0);
        kontrol({on_ek, "_durdur"},      32'(bus.durdur_o),            32'd0);
        kontrol({on_ek, "_guc_gecerli"}, 32'(bus.guncelle_gecerli_o),  32'd0);
        kontrol({on_ek, "_guc_ps"},      bus.guncelle_ps_o,            32'd0);
        kontrol({on_ek, "_dal_sayisi"},  bus.dal_sayisi_o,             32'd0);
        kontrol({on_ek, "_hata_sayisi"}, bus.hata_sayisi_o,            32'd0);
    endtask

    initial begin
        hatalar    = 0;
        kontroller = 0;
        rst_i      = 1'b0;
        girisleri_sil();
        bus.getir_hazir_i    = 1'b0;
        bus.ongorucu_hazir_i = 1'b0;

        // Reset state
        #2;
        hepsi_sifir("reset");
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Taken mispredict, fetch ready: redirect 0x200, one flush, one update queued
        bus.getir_hazir_i = 1'b1;
        dal(1'b1, 1'b1, 32'h100, 32'h200);
        #1;
        kontrol("t1_temizle_bosta", 32'(bus.temizle_o), 32'd0);
        adim();
        girisleri_sil();
        kontrol("t1_yon_gecerli", 32'(bus.yonlendir_gecerli_o), 32'd1);
        kontrol("t1_yon_ps",      bus.yonlendir_ps_o,           32'h200);
        kontrol("t1_durdur",      32'(bus.durdur_o),            32'd1);
        kontrol("t1_temizle",     32'(bus.temizle_o),           32'd1);
        kontrol("t1_guc_gecerli", 32'(bus.guncelle_gecerli_o),  32'd1);
        kontrol("t1_guc_ps",      bus.guncelle_ps_o,            32'h100);
        kontrol("t1_guc_atladi",  32'(bus.guncelle_atladi_o),   32'd1);
        kontrol("t1_guc_hedef",   bus.guncelle_hedef_o,         32'h200);
        adim();
        kontrol("t1_yon_bitti",   32'(bus.yonlendir_gecerli_o), 32'd0);
        kontrol("t1_temizle_tek", 32'(bus.temizle_o),           32'd0);
        kontrol("t1_durdur_bitti", 32'(bus.durdur_o),           32'd0);
        kontrol("t1_kuyrukta",    32'(bus.guncelle_gecerli_o),  32'd1);
        bus.ongorucu_hazir_i = 1'b1;
        adim();
        kontrol("t1_cekildi",     32'(bus.guncelle_gecerli_o),  32'd0);

        // Not-taken mispredict, fetch stalled 3 cycles; wrong-path inputs ignored
        bus.getir_hazir_i = 1'b0;
        dal(1'b1, 1'b0, 32'h100, 32'h200);
        adim();
        dal(1'b1, 1'b1, 32'h700, 32'h800);
        bus.atlama_gecerli_i = 1'b1;
        bus.atlama_hedef_i   = 32'h900;
        for (int i = 0; i < 3; i++) begin
            kontrol("t2_yon_gecerli", 32'(bus.yonlendir_gecerli_o), 32'd1);
            kontrol("t2_yon_ps",      bus.yonlendir_ps_o,           32'h104);
            kontrol("t2_durdur",      32'(bus.durdur_o),            32'd1);
            kontrol("t2_temizle",     32'(bus.temizle_o),           32'd0);
            kontrol("t2_guc_gecerli", 32'(bus.guncelle_gecerli_o),  (i == 0) ? 32'd1 : 32'd0);
            adim();
        end
        girisleri_sil();
        bus.getir_hazir_i = 1'b1;
        #1;
        kontrol("t2_temizle_kabul", 32'(bus.temizle_o),     32'd1);
        kontrol("t2_yon_ps_kabul",  bus.yonlendir_ps_o,     32'h104);
        adim();
        kontrol("t2_yon_bitti",   32'(bus.yonlendir_gecerli_o), 32'd0);
        kontrol("t2_temizle_son", 32'(bus.temizle_o),           32'd0);
        kontrol("t2_durdur_son",  32'(bus.durdur_o),            32'd0);

        // Simultaneous mispredict (0x300) and jump (0x400): branch wins
        dal(1'b1, 1'b1, 32'h120, 32'h300);
        bus.atlama_gecerli_i = 1'b1;
        bus.atlama_hedef_i   = 32'h400;
        adim();
        girisleri_sil();
        kontrol("t3_yon_gecerli", 32'(bus.yonlendir_gecerli_o), 32'd1);
        kontrol("t3_yon_ps",      bus.yonlendir_ps_o,           32'h300);
        adim();
        kontrol("t3_atlama_atildi", 32'(bus.yonlendir_gecerli_o), 32'd0);

        // Jump alone redirects and is not queued
        bus.atlama_gecerli_i = 1'b1;
        bus.atlama_hedef_i   = 32'h400;
        adim();
        girisleri_sil();
        kontrol("t4_yon_ps",      bus.yonlendir_ps_o,          32'h400);
        kontrol("t4_guc_gecerli", 32'(bus.guncelle_gecerli_o), 32'd0);
        adim();

        // Five correct branches with predictor stalled: 4 queued, 5th after first pop
        bus.ongorucu_hazir_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dal(1'b0, 1'b0, 32'h600 + 32'(4 * i), 32'h0);
            adim();
        end
        kontrol("t5_durdur_dolu", 32'(bus.durdur_o),            32'd1);
        kontrol("t5_guc_gecerli", 32'(bus.guncelle_gecerli_o),  32'd1);
        kontrol("t5_bas_600",     bus.guncelle_ps_o,            32'h600);
        dal(1'b0, 1'b0, 32'h610, 32'h0);
        adim();
        kontrol("t5_red_durdur",  32'(bus.durdur_o),            32'd1);
        kontrol("t5_red_bas",     bus.guncelle_ps_o,            32'h600);
        bus.ongorucu_hazir_i = 1'b1;
        adim();
        kontrol("t5_pop_durdur",  32'(bus.durdur_o),            32'd0);
        kontrol("t5_pop_bas",     bus.guncelle_ps_o,            32'h604);
        bus.ongorucu_hazir_i = 1'b0;
        adim();
        girisleri_sil();
        kontrol("t5_besinci_durdur", 32'(bus.durdur_o),         32'd1);
        kontrol("t5_besinci_bas",    bus.guncelle_ps_o,         32'h604);
        bus.ongorucu_hazir_i = 1'b1;
        adim();
        kontrol("t5_bas_608",     bus.guncelle_ps_o,            32'h608);
        adim();
        kontrol("t5_bas_60c",     bus.guncelle_ps_o,            32'h60C);
        adim();
        kontrol("t5_bas_610",     bus.guncelle_ps_o,            32'h610);
        adim();
        kontrol("t5_bos",         32'(bus.guncelle_gecerli_o),  32'd0);

        // Reset asserted mid-redirect
        bus.getir_hazir_i    = 1'b0;
        bus.ongorucu_hazir_i = 1'b0;
        dal(1'b1, 1'b1, 32'h140, 32'h240);
        adim();
        girisleri_sil();
        kontrol("t6_yon_once",    32'(bus.yonlendir_gecerli_o), 32'd1);
        kontrol("t6_kuyruk_once", 32'(bus.guncelle_gecerli_o),  32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        hepsi_sifir("t6_reset");
        adim();
        rst_i = 1'b1;
        bus.getir_hazir_i    = 1'b1;
        bus.ongorucu_hazir_i = 1'b1;
        adim();
        kontrol("t6_bosta",       32'(bus.yonlendir_gecerli_o), 32'd0);
        kontrol("t6_durdur",      32'(bus.durdur_o),            32'd0);

        // Three branches, one mispredict: counters
        dal(1'b0, 1'b0, 32'h500, 32'h0);
        adim();
        dal(1'b0, 1'b1, 32'h504, 32'h580);
        adim();
        dal(1'b1, 1'b0, 32'h508, 32'h0);
        adim();
        girisleri_sil();
        kontrol("t7_yon_ps",      bus.yonlendir_ps_o,           32'h50C);
        adim();
`ifdef DALLANMA_SAYAC_EN
        kontrol("t7_dal_sayisi",  bus.dal_sayisi_o,             32'd3);
        kontrol("t7_hata_sayisi", bus.hata_sayisi_o,            32'd1);
`else
        kontrol("t7_dal_sayisi",  bus.dal_sayisi_o,             32'd0);
        kontrol("t7_hata_sayisi", bus.hata_sayisi_o,            32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", hatalar, kontroller);
        $finish;
    end

endmodule

// File: doc/dallanma_denetleyici.md
DALLANMA_DENETLEYICI -- requirements
Module: dallanma_denetleyici

Interface
REQ-001 SHALL provide parameter PS_W, default 32, program-counter width.
REQ-002 SHALL provide parameter FIFO_DERINLIK, default 4, predictor-update queue depth (power of two, at least 2).
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all state SHALL be on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit, reset; asynchronous, active-low.
REQ-005 SHALL have port dal_gecerli_i, input, 1 bit, resolved conditional branch present in execute.
REQ-006 SHALL have ports dal_hata_i and dal_atladi_i, input, 1 bit each: mispredict flag and actual taken outcome from the branch unit.
REQ-007 SHALL have ports dal_ps_i and dal_hedef_i, input, PS_W each: branch PC and taken target.
REQ-008 SHALL have ports atlama_gecerli_i (1 bit) and atlama_hedef_i (PS_W), input: unconditional jump redirect request.
REQ-009 SHALL have ports getir_hazir_i and ongorucu_hazir_i, input, 1 bit each: fetch accepts redirect; predictor accepts update.
REQ-010 SHALL have ports yonlendir_gecerli_o (1 bit) and yonlendir_ps_o (PS_W), output: redirect to fetch.
REQ-011 SHALL have ports temizle_o and durdur_o, output, 1 bit each: flush IF/ID; stall execute.
REQ-012 SHALL have ports guncelle_gecerli_o, guncelle_atladi_o (1 bit) and guncelle_ps_o, guncelle_hedef_o (PS_W), output: predictor update from queue head.
REQ-013 SHALL have ports dal_sayisi_o and hata_sayisi_o, output, 32 bits each: performance counters.

Function
REQ-014 SHALL implement FSM states BOSTA and YONLENDIR.
REQ-015 In BOSTA, dal_gecerli_i with dal_hata_i, queue not full, SHALL latch a redirect PC (dal_hedef_i if dal_atladi_i, else dal_ps_i+4, modulo 2^PS_W) and go to YONLENDIR.
REQ-016 In BOSTA, atlama_gecerli_i without a mispredicting branch SHALL latch atlama_hedef_i and go to YONLENDIR.
REQ-017 A simultaneous mispredicting branch and jump SHALL take the branch redirect and discard the jump.
REQ-018 In YONLENDIR, yonlendir_gecerli_o SHALL be 1 with the latched PC, held stable until getir_hazir_i.
REQ-019 A cycle with yonlendir_gecerli_o and getir_hazir_i both high SHALL assert temizle_o for exactly that cycle and return to BOSTA next cycle.
REQ-020 In YONLENDIR, dal_gecerli_i and atlama_gecerli_i (wrong path) SHALL be ignored: no enqueue, no redirect, no count.
REQ-021 In YONLENDIR, durdur_o SHALL be 1.
REQ-022 Each dal_gecerli_i accepted in BOSTA (queue not full) SHALL enqueue {dal_ps_i, dal_atladi_i, dal_hedef_i}, with one-cycle latency to guncelle_gecerli_o when the queue is empty.
REQ-023 durdur_o SHALL be 1 whenever the registered queue count equals FIFO_DERINLIK.
REQ-024 A push while full SHALL be refused with no state change; execute holds its inputs under durdur_o.
REQ-025 Pop SHALL occur when guncelle_gecerli_o and ongorucu_hazir_i are both high.
REQ-026 Simultaneous push and pop when not full SHALL leave the count unchanged.
REQ-027 guncelle_gecerli_o SHALL be 1 iff the count is nonzero.
REQ-028 Read and write pointers SHALL wrap modulo FIFO_DERINLIK.

Reset
REQ-029 Reset low SHALL immediately force state BOSTA, queue empty, pointers 0, counters 0, and every output 0, including mid-redirect.

Configuration
REQ-030 With DALLANMA_SAYAC_EN defined, dal_sayisi_o SHALL count accepted branches and hata_sayisi_o accepted mispredicts, both saturating at 2^32-1.
REQ-031 Without DALLANMA_SAYAC_EN, both counter ports SHALL remain present and constant 0, and no counter flops SHALL be generated.

Structure
REQ-032 State encodings (BOSTA, YONLENDIR) and the instruction-size constant 4 SHALL live in the shared package/include alongside the branch-type codes.
REQ-033 The update queue SHALL be one sub-module, dallanma_guncelle_fifo, parameterised by width and depth.

Verification
REQ-034 The bench SHALL cover: branch PC 0x100, taken, mispredict, target 0x200, getir_hazir_i=1 -> redirect 0x200 next cycle, temizle_o one cycle, one update queued.
REQ-035 The bench SHALL cover: not-taken mispredict at PC 0x100, getir_hazir_i low 3 cycles -> yonlendir_ps_o=0x104 held 3 cycles with durdur_o=1, temizle_o only on the accept cycle.
REQ-036 The bench SHALL cover: same-cycle mispredict (target 0x300) and jump (0x400) -> redirect 0x300 only.
REQ-037 The bench SHALL cover: 5 correct branches with ongorucu_hazir_i=0 -> 4 queued, durdur_o=1, 5th accepted the cycle after the first pop.
REQ-038 The bench SHALL cover: rst_i low during YONLENDIR -> all outputs 0 immediately, BOSTA after release.
REQ-039 The bench SHALL cover: with DALLANMA_SAYAC_EN, 3 branches with 1 mispredict -> dal_sayisi_o=3, hata_sayisi_o=1; without the macro, both stay 0.
